// File: rtl/mul_seq_nch.sv
// Multi-channel sequential multiplier: one radix-2 shift-add engine walks the
// channels in order, with signed handling, half-up fixed-point rounding and saturation.
module mul_seq_nch #(
  parameter int C_WIDTH     = 16,
  parameter int FIXED_POINT = 0,
  parameter int NUM_CH      = 4,
  parameter int SIGNED      = 1,
  parameter int SATURATE    = 1
) (
  input  logic                        ctl_clk,
  input  logic                        reset,
  input  logic                        trigger,
  input  logic [NUM_CH*C_WIDTH-1:0]   a,
  input  logic [NUM_CH*C_WIDTH-1:0]   b,
  output logic [NUM_CH*C_WIDTH-1:0]   y,
  output logic [NUM_CH-1:0]           ovf,
  output logic                        ready,
  output logic                        done
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BW  = (C_WIDTH > 1) ? $clog2(C_WIDTH) : 1;
  localparam int PW  = 2*C_WIDTH + 2;
  localparam int RND_SH = (FIXED_POINT > 0) ? FIXED_POINT - 1 : 0;
  localparam logic signed [PW-1:0] MAXV = (SIGNED != 0) ? PW'({(C_WIDTH-1){1'b1}})
                                                        : PW'({C_WIDTH{1'b1}});
  localparam logic signed [PW-1:0] MINV = (SIGNED != 0) ? ~PW'({(C_WIDTH-1){1'b1}}) : '0;
  localparam logic signed [PW-1:0] RND  = (FIXED_POINT > 0) ? (PW'(1) << RND_SH) : '0;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                             r_state;
  logic [NUM_CH-1:0][C_WIDTH-1:0]     r_a, r_b, r_buf_y;
  logic [NUM_CH-1:0]                  r_buf_ovf;
  logic [CHW-1:0]                     r_ch;
  logic [BW-1:0]                      r_bit;
  logic [2*C_WIDTH-1:0]               r_p;

  logic [C_WIDTH-1:0]   w_opa, w_opb, w_mag_a, w_mag_b;
  logic                 w_sa, w_sb, w_neg;
  logic [2*C_WIDTH-1:0] w_p_cur, w_p_next;
  logic [C_WIDTH:0]     w_upper;
  logic [PW-1:0]        w_ext;
  logic signed [PW-1:0] w_full, w_rnd, w_shft;
  logic                 w_hi, w_lo, w_ovf_ch, w_last_bit, w_last_ch;
  logic [C_WIDTH-1:0]   w_y_ch;

  assign w_opa   = r_a[r_ch];
  assign w_opb   = r_b[r_ch];
  assign w_sa    = (SIGNED != 0) && w_opa[C_WIDTH-1];
  assign w_sb    = (SIGNED != 0) && w_opb[C_WIDTH-1];
  assign w_neg   = w_sa ^ w_sb;
  // Magnitudes stay C_WIDTH-bit unsigned so the most negative value is exact.
  assign w_mag_a = w_sa ? (~w_opa + C_WIDTH'(1)) : w_opa;
  assign w_mag_b = w_sb ? (~w_opb + C_WIDTH'(1)) : w_opb;

  // Classic product register: upper half accumulates, lower half shifts out multiplier bits.
  assign w_p_cur  = (r_bit == '0) ? {{C_WIDTH{1'b0}}, w_mag_b} : r_p;
  assign w_upper  = {1'b0, w_p_cur[2*C_WIDTH-1:C_WIDTH]}
                  + {1'b0, (w_p_cur[0] ? w_mag_a : {C_WIDTH{1'b0}})};
  assign w_p_next = {w_upper, w_p_cur[C_WIDTH-1:1]};

  assign w_ext  = {2'b00, w_p_next};
  assign w_full = w_neg ? $signed(~w_ext + PW'(1)) : $signed(w_ext);
  assign w_rnd  = w_full + RND;
  assign w_shft = w_rnd >>> FIXED_POINT;

  assign w_hi     = (w_shft > MAXV);
  assign w_lo     = (w_shft < MINV);
  assign w_ovf_ch = w_hi | w_lo;
  assign w_y_ch   = ((SATURATE != 0) && w_hi) ? MAXV[C_WIDTH-1:0] :
                    ((SATURATE != 0) && w_lo) ? MINV[C_WIDTH-1:0] : w_shft[C_WIDTH-1:0];

  assign w_last_bit = (r_bit == BW'(C_WIDTH-1));
  assign w_last_ch  = (r_ch == CHW'(NUM_CH-1));

  always_ff @(posedge ctl_clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_buf_y   <= '0;
      r_buf_ovf <= '0;
      r_ch      <= '0;
      r_bit     <= '0;
      r_p       <= '0;
      y         <= '0;
      ovf       <= '0;
      ready     <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (ready && trigger) begin
            r_a     <= a;
            r_b     <= b;
            r_ch    <= '0;
            r_bit   <= '0;
            ready   <= 1'b0;
            r_state <= CALC;
          end else begin
            ready <= 1'b1;
          end
        end
        CALC: begin
          r_p   <= w_p_next;
          r_bit <= r_bit + BW'(1);
          if (w_last_bit) begin
            r_bit           <= '0;
            r_buf_y[r_ch]   <= w_y_ch;
            r_buf_ovf[r_ch] <= w_ovf_ch;
            if (w_last_ch) r_state <= DONE;
            else           r_ch    <= r_ch + CHW'(1);
          end
        end
        DONE: begin
          y       <= r_buf_y;
          ovf     <= r_buf_ovf;
          done    <= 1'b1;
          ready   <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_seq_nch.sv
// Scoreboard bench for mul_seq_nch: five parameter variants share one stimulus,
// expected results come from an integer reference model.
module tb_mul_seq_nch;
  logic clk = 1'b0, rst_n = 1'b1, trig = 1'b0;
  logic [63:0] a_i = '0, b_i = '0;
  logic [4:0][63:0] yv;
  logic [4:0][3:0]  ov;
  logic [4:0]       rdy, dn;
  int n_chk = 0, n_fail = 0;

  // cfg: 0 signed/sat, 1 signed/trunc, 2 unsigned/sat, 3 unsigned/trunc, 4 signed/sat Q8
  int cfg_s [5] = '{1, 1, 0, 0, 1};
  int cfg_t [5] = '{1, 0, 1, 0, 1};
  int cfg_f [5] = '{0, 0, 0, 0, 8};

  typedef struct packed {
    logic [4:0][63:0] y;
    logic [4:0][3:0]  o;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mul_seq_nch #(.SIGNED(1), .SATURATE(1), .FIXED_POINT(0)) u0 (.ctl_clk(clk), .reset(rst_n),
    .trigger(trig), .a(a_i), .b(b_i), .y(yv[0]), .ovf(ov[0]), .ready(rdy[0]), .done(dn[0]));
  mul_seq_nch #(.SIGNED(1), .SATURATE(0), .FIXED_POINT(0)) u1 (.ctl_clk(clk), .reset(rst_n),
    .trigger(trig), .a(a_i), .b(b_i), .y(yv[1]), .ovf(ov[1]), .ready(rdy[1]), .done(dn[1]));
  mul_seq_nch #(.SIGNED(0), .SATURATE(1), .FIXED_POINT(0)) u2 (.ctl_clk(clk), .reset(rst_n),
    .trigger(trig), .a(a_i), .b(b_i), .y(yv[2]), .ovf(ov[2]), .ready(rdy[2]), .done(dn[2]));
  mul_seq_nch #(.SIGNED(0), .SATURATE(0), .FIXED_POINT(0)) u3 (.ctl_clk(clk), .reset(rst_n),
    .trigger(trig), .a(a_i), .b(b_i), .y(yv[3]), .ovf(ov[3]), .ready(rdy[3]), .done(dn[3]));
  mul_seq_nch #(.SIGNED(1), .SATURATE(1), .FIXED_POINT(8)) u4 (.ctl_clk(clk), .reset(rst_n),
    .trigger(trig), .a(a_i), .b(b_i), .y(yv[4]), .ovf(ov[4]), .ready(rdy[4]), .done(dn[4]));

  function automatic exp_t model(input logic [63:0] av, input logic [63:0] bv);
    exp_t e;
    longint x, z, p, lo, hi;
    logic [15:0] ca, cb;
    e = '0;
    for (int k = 0; k < 5; k++) begin
      for (int n = 0; n < 4; n++) begin
        ca = av[n*16 +: 16];
        cb = bv[n*16 +: 16];
        if (cfg_s[k] != 0) begin
          x = longint'($signed(ca)); z = longint'($signed(cb)); lo = -32768; hi = 32767;
        end else begin
          x = longint'({48'd0, ca}); z = longint'({48'd0, cb}); lo = 0; hi = 65535;
        end
        p = x * z;
        if (cfg_f[k] > 0) p = (p + (longint'(1) << (cfg_f[k] - 1))) >>> cfg_f[k];
        e.o[k][n] = (p > hi) || (p < lo);
        if (cfg_t[k] != 0 && p > hi) p = hi;
        else if (cfg_t[k] != 0 && p < lo) p = lo;
        e.y[k][n*16 +: 16] = p[15:0];
      end
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_op(input logic [63:0] av, input logic [63:0] bv);
    a_i = av; b_i = bv; trig = 1'b1;
    sb.push_back(model(av, bv));
    tick();
    trig = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin tick(); n++; end while (dn[0] !== 1'b1 && n < 300);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #10;
    n_chk++;
    if (rdy !== 5'h00 || dn !== 5'h00 || yv !== '0 || ov !== '0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b done=%b y0=%h ovf0=%b, want all zero", rdy, dn, yv[0], ov[0]);
    end
    tick();
    rst_n = 1'b1; trig = 1'b1;
    #2;
    n_chk++;
    if (rdy !== 5'h00) begin n_fail++; $display("FAIL ready_before_edge: ready=%b, want 00000", rdy); end
    tick();
    trig = 1'b0;
    n_chk++;
    if (rdy !== 5'h1f) begin n_fail++; $display("FAIL ready_first_edge: ready=%b, want 11111", rdy); end
    tick();
    n_chk++;
    if (rdy !== 5'h1f) begin n_fail++; $display("FAIL trigger_on_release: ready=%b, want 11111", rdy); end
  endtask

  task automatic test_basic();
    exp_t e; int n;
    start_op(64'h7FFF_FFFD_0024_0003, 64'h0002_0005_0073_0002);
    wait_done(n);
    n_chk++;
    if (n != 65) begin n_fail++; $display("FAIL basic_latency: %0d cycles, want 65", n); end
    n_chk++;
    if (yv[0] !== 64'h7FFF_FFF1_102C_0006 || ov[0] !== 4'b1000) begin
      n_fail++; $display("FAIL basic_const: y=%h ovf=%b, want 7fff_fff1_102c_0006 ovf=1000", yv[0], ov[0]);
    end
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      n_chk++;
      if (yv[k] !== e.y[k] || ov[k] !== e.o[k]) begin
        n_fail++; $display("FAIL basic_cfg%0d: y=%h ovf=%b, want y=%h ovf=%b", k, yv[k], ov[k], e.y[k], e.o[k]);
      end
    end
    tick();
    n_chk++;
    if (dn !== 5'h00) begin n_fail++; $display("FAIL done_pulse_width: done=%b, want 00000", dn); end
  endtask

  task automatic test_fixed();
    exp_t e; int n;
    start_op(64'h0000_0000_0001_0180, 64'h0000_0000_0080_0180);
    wait_done(n);
    n_chk++;
    if (yv[4][31:0] !== 32'h0001_0240 || ov[4] !== 4'b0000) begin
      n_fail++; $display("FAIL fixed_round: y=%h ovf=%b, want 0001_0240 ovf=0000", yv[4][31:0], ov[4]);
    end
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      n_chk++;
      if (yv[k] !== e.y[k] || ov[k] !== e.o[k]) begin
        n_fail++; $display("FAIL fixed_cfg%0d: y=%h ovf=%b, want y=%h ovf=%b", k, yv[k], ov[k], e.y[k], e.o[k]);
      end
    end
  endtask

  task automatic test_corner();
    exp_t e; int n;
    start_op(64'h1234_0000_FFFF_8000, 64'h5678_ABCD_FFFF_8000);
    wait_done(n);
    n_chk++;
    if (n != 65) begin n_fail++; $display("FAIL zero_latency: %0d cycles, want 65", n); end
    n_chk++;
    if (yv[0][15:0] !== 16'h7FFF || ov[0][0] !== 1'b1 || yv[1][15:0] !== 16'h0000 || ov[1][0] !== 1'b1) begin
      n_fail++; $display("FAIL min_times_min: sat=%h/%b trunc=%h/%b, want 7fff/1 0000/1",
                         yv[0][15:0], ov[0][0], yv[1][15:0], ov[1][0]);
    end
    n_chk++;
    if (yv[2][31:16] !== 16'hFFFF || ov[2][1] !== 1'b1 || yv[3][31:16] !== 16'h0001 || ov[3][1] !== 1'b1) begin
      n_fail++; $display("FAIL unsigned_max: sat=%h/%b trunc=%h/%b, want ffff/1 0001/1",
                         yv[2][31:16], ov[2][1], yv[3][31:16], ov[3][1]);
    end
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      n_chk++;
      if (yv[k] !== e.y[k] || ov[k] !== e.o[k]) begin
        n_fail++; $display("FAIL corner_cfg%0d: y=%h ovf=%b, want y=%h ovf=%b", k, yv[k], ov[k], e.y[k], e.o[k]);
      end
    end
  endtask

  task automatic test_ignore_trigger();
    exp_t e; int n, extra;
    start_op(64'h0100_FF00_0033_7FFE, 64'h0100_0100_0044_0003);
    repeat (10) tick();
    a_i = {$urandom, $urandom}; b_i = {$urandom, $urandom}; trig = 1'b1;
    tick();
    trig = 1'b0;
    wait_done(n);
    n_chk++;
    if (n + 11 != 65) begin n_fail++; $display("FAIL busy_latency: %0d cycles, want 65", n + 11); end
    e = sb.pop_front();
    extra = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (c == 5) begin a_i = {$urandom, $urandom}; b_i = {$urandom, $urandom}; end
      if (dn[0] === 1'b1) extra++;
      n_chk++;
      if (yv[0] !== e.y[0] || ov[0] !== e.o[0]) begin
        n_fail++; $display("FAIL hold_cycle%0d: y=%h ovf=%b, want y=%h ovf=%b", c, yv[0], ov[0], e.y[0], e.o[0]);
      end
    end
    n_chk++;
    if (extra != 0) begin n_fail++; $display("FAIL ignored_trigger: %0d extra done pulses, want 0", extra); end
  endtask

  task automatic test_reset_mid();
    exp_t e; int n, seen;
    start_op(64'h1111_2222_3333_4444, 64'h0005_0006_0007_0008);
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (yv !== '0 || ov !== '0 || dn !== 5'h00 || rdy !== 5'h00) begin
      n_fail++; $display("FAIL abort_state: y0=%h ovf0=%b done=%b ready=%b, want zeros", yv[0], ov[0], dn, rdy);
    end
    void'(sb.pop_back());
    tick(); tick();
    rst_n = 1'b1;
    seen = 0;
    tick();
    n_chk++;
    if (rdy !== 5'h1f) begin n_fail++; $display("FAIL ready_after_abort: ready=%b, want 11111", rdy); end
    for (int c = 0; c < 70; c++) begin tick(); if (dn[0] === 1'b1) seen++; end
    n_chk++;
    if (seen != 0 || yv[0] !== 64'h0) begin
      n_fail++; $display("FAIL abort_no_done: %0d pulses y=%h, want 0 pulses y=0", seen, yv[0]);
    end
    start_op(64'hFFFF_0001_8001_7FFF, 64'h0002_FFFF_0003_7FFF);
    wait_done(n);
    n_chk++;
    if (n != 65) begin n_fail++; $display("FAIL retrigger_latency: %0d cycles, want 65", n); end
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      n_chk++;
      if (yv[k] !== e.y[k] || ov[k] !== e.o[k]) begin
        n_fail++; $display("FAIL retrigger_cfg%0d: y=%h ovf=%b, want y=%h ovf=%b", k, yv[k], ov[k], e.y[k], e.o[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; int n;
    logic [63:0] av, bv;
    av = {$urandom, $urandom}; bv = {$urandom, $urandom};
    a_i = av; b_i = bv; trig = 1'b1;
    sb.push_back(model(av, bv));
    tick();
    for (int i = 0; i < 3; i++) begin
      wait_done(n);
      n_chk++;
      if (n != ((i == 0) ? 65 : 66)) begin
        n_fail++; $display("FAIL b2b_spacing%0d: %0d cycles, want %0d", i, n, (i == 0) ? 65 : 66);
      end
      e = sb.pop_front();
      for (int k = 0; k < 5; k++) begin
        n_chk++;
        if (yv[k] !== e.y[k] || ov[k] !== e.o[k]) begin
          n_fail++; $display("FAIL b2b%0d_cfg%0d: y=%h ovf=%b, want y=%h ovf=%b", i, k, yv[k], ov[k], e.y[k], e.o[k]);
        end
      end
      if (i < 2) begin
        av = {$urandom, $urandom}; bv = {$urandom, $urandom};
        a_i = av; b_i = bv;
        sb.push_back(model(av, bv));
      end else begin
        trig = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fixed();
    test_corner();
    test_ignore_trigger();
    test_reset_mid();
    test_back_to_back();
    n_chk++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: %0d left, want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_seq_nch.md
MUL_SEQ_NCH -- requirements
Module: mul_seq_nch

Interface
REQ-001 The block SHALL take parameter C_WIDTH, default 16: operand and result width in bits.
REQ-002 The block SHALL take parameter FIXED_POINT, default 0: fractional bits in operands and result, with range 0..C_WIDTH-1.
REQ-003 The block SHALL take parameter NUM_CH, default 4: number of independent channels, at least 1.
REQ-004 The block SHALL take parameter SIGNED, default 1: 1 means two's-complement operands and result; 0 means unsigned.
REQ-005 The block SHALL take parameter SATURATE, default 1: 1 means clamp out-of-range results; 0 means truncate them.
REQ-006 Port ctl_clk SHALL be an input, 1 bit: the single clock; all state changes on the rising edge.
REQ-007 Port reset SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-008 Port trigger SHALL be an input, 1 bit: start request.
REQ-009 Port a SHALL be an input, NUM_CH*C_WIDTH bits: packed operand A; channel n occupies bits [n*C_WIDTH +: C_WIDTH].
REQ-010 Port b SHALL be an input, NUM_CH*C_WIDTH bits: packed operand B, packed the same way as a.
REQ-011 Port y SHALL be an output, NUM_CH*C_WIDTH bits: packed registered results.
REQ-012 Port ovf SHALL be an output, NUM_CH bits: per-channel registered overflow flags.
REQ-013 Port ready SHALL be an output, 1 bit: the block is idle and accepts trigger.
REQ-014 Port done SHALL be an output, 1 bit: single-cycle pulse marking that new y and ovf values are valid.

Function
REQ-015 The block SHALL use one shared radix-2 shift-add engine that processes channels serially, 0 to NUM_CH-1.
REQ-016 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-017 In IDLE with ready=1, trigger=1 sampled at an edge SHALL capture a and b into internal registers, clear the channel and bit counters, and enter CALC.
REQ-018 In CALC, each cycle SHALL process one multiplier bit; after C_WIDTH cycles the channel result SHALL be written to an internal result buffer and the channel counter SHALL advance.
REQ-019 After the last channel completes, the FSM SHALL enter DONE, where y and ovf are loaded from the buffer at that same edge and done=1 for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-020 Latency SHALL be fixed: done=1 exactly NUM_CH*C_WIDTH+1 cycles after the edge that sampled trigger.
REQ-021 ready SHALL be 1 only in IDLE and 0 in CALC and DONE.
REQ-022 trigger while ready=0 SHALL be ignored and never queued.
REQ-023 Changes on a and b after capture SHALL NOT affect the current operation.
REQ-024 y and ovf SHALL remain stable from one DONE to the next.
REQ-025 With SIGNED=1, the engine SHALL multiply operand magnitudes, held as C_WIDTH-bit unsigned values so that -2^(C_WIDTH-1) is exact, and negate the 2*C_WIDTH-bit product when the operand signs differ.
REQ-026 With FIXED_POINT>0, the full product SHALL be rounded half-up by adding 2^(FIXED_POINT-1) and then shifted right by FIXED_POINT (arithmetic shift when signed).
REQ-027 ovf[n] SHALL be 1 when the rounded, shifted result lies outside the C_WIDTH range: signed [-2^(C_WIDTH-1), 2^(C_WIDTH-1)-1] or unsigned [0, 2^C_WIDTH-1]; this check SHALL be independent of SATURATE.
REQ-028 On overflow with SATURATE=1, y[n] SHALL be clamped to the nearest range bound; with SATURATE=0, y[n] SHALL be the low C_WIDTH bits.
REQ-029 A zero operand SHALL take the same latency as any other operand; there SHALL be no early termination.
REQ-030 trigger held high continuously SHALL start a new operation on the first IDLE cycle after each DONE.

Reset
REQ-031 While reset=0, the block SHALL hold state IDLE, with ready=0, done=0, y=0 and ovf=0, and all counters and capture registers cleared.
REQ-032 reset asserted mid-CALC SHALL abort the operation immediately, with no done pulse and y=0.
REQ-033 ready SHALL rise at the first ctl_clk edge after reset deasserts; trigger on that edge SHALL be ignored.

Verification
REQ-034 Defaults with a={0x7FFF,0xFFFD,0x0024,0x0003} (ch3..ch0) and b={0x0002,0x0005,0x0073,0x0002} -> y={0x7FFF,0xFFF1,0x102C,0x0006}, ovf=4'b1000, done exactly 65 cycles after the trigger edge.
REQ-035 FIXED_POINT=8 with ch0 0x0180*0x0180 and ch1 0x0001*0x0080 -> y ch0=0x0240 and ch1=0x0001 (half-up rounding), ovf=0.
REQ-036 ch0 0x8000*0x8000 with SIGNED=1 -> SATURATE=1 gives 0x7FFF with ovf[0]=1; SATURATE=0 gives 0x0000 with ovf[0]=1.
REQ-037 trigger pulsed again 10 cycles into CALC with new operands -> ignored; the first results are unchanged and there is only one done pulse.
REQ-038 reset asserted 20 cycles into CALC, then released -> y=0, ovf=0, no done; ready=1 one edge after release; a retrigger completes normally in 65 cycles.
REQ-039 SIGNED=0 with 0xFFFF*0xFFFF -> y=0xFFFF when SATURATE=1, 0x0001 when SATURATE=0, ovf=1 in both cases.
